// File: rtl/sensor_input_conditioner_pkg.sv
// home_auto_pkg: shared widths and types for the home-automation sensor front end
package home_auto_pkg;
    localparam int SENSOR_W     = 4;
    localparam int TEMP_W       = 6;
    localparam int AVG_DEPTH    = 4;
    localparam int DEBOUNCE_CYC = 8;
    typedef logic [SENSOR_W-1:0] sensor_t;
    typedef logic [TEMP_W-1:0]   temp_t;
    typedef logic [TEMP_W+1:0]   sum_t;
endpackage

// File: rtl/sensor_input_conditioner_if.sv
// sensor_input_conditioner_if: raw sensor/temperature inputs and conditioned outputs
interface sensor_input_conditioner_if;
    import home_auto_pkg::*;
    sensor_t sensors_raw;
    temp_t   temp_raw;
    logic    temp_valid;
    sensor_t sensors;
    temp_t   temp;
    logic    temp_ready;
    modport master (output sensors_raw, temp_raw, temp_valid, input sensors, temp, temp_ready);
    modport slave  (input sensors_raw, temp_raw, temp_valid, output sensors, temp, temp_ready);
endinterface

// File: rtl/sensor_input_conditioner_debounce.sv
// sensor_debounce: two-flop synchroniser plus stable-count debounce for one sensor bit
module sensor_debounce #(
    parameter int DEBOUNCE_CYC = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_raw,
    output logic o_bit
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);
    logic             r_meta;
    logic             r_sync;
    logic [CNT_W-1:0] r_cnt;
    // bring the asynchronous contact into the clock domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_raw;
            r_sync <= r_meta;
        end
    end
    // count consecutive disagreeing cycles; toggle the output once the run is long enough
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            o_bit <= 1'b0;
        end else if (r_sync == o_bit) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_W'(DEBOUNCE_CYC - 1)) begin
            r_cnt <= '0;
            o_bit <= ~o_bit;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/sensor_input_conditioner.sv
// sensor_input_conditioner: debounces sensor contacts and filters temperature samples (TEMP_AVG_EN enables 4-sample averaging)
module sensor_input_conditioner
    import home_auto_pkg::*;
#(
    parameter int DEBOUNCE_CYC = home_auto_pkg::DEBOUNCE_CYC
) (
    input logic                         clk,
    input logic                         rst_n,
    sensor_input_conditioner_if.slave   bus
);
    sensor_t w_sensors;
    temp_t   r_temp;
    logic    r_ready;

    for (genvar i = 0; i < SENSOR_W; i++) begin : g_db
        sensor_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
            .clk   (clk),
            .rst_n (rst_n),
            .i_raw (bus.sensors_raw[i]),
            .o_bit (w_sensors[i])
        );
    end

    // temp_ready latches on the first accepted sample and holds until reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_ready <= 1'b0;
        else if (bus.temp_valid) r_ready <= 1'b1;
    end

`ifdef TEMP_AVG_EN
    temp_t r_win [AVG_DEPTH];
    temp_t w_win_nxt [AVG_DEPTH];
    sum_t  w_sum;
    // next window: first sample fills every slot, later samples shift in at the top
    always_comb begin
        for (int k = 0; k < AVG_DEPTH - 1; k++) w_win_nxt[k] = r_ready ? r_win[k+1] : bus.temp_raw;
        w_win_nxt[AVG_DEPTH-1] = bus.temp_raw;
        w_sum = '0;
        for (int k = 0; k < AVG_DEPTH; k++) w_sum = w_sum + sum_t'(w_win_nxt[k]);
    end
    // commit window and its truncated average on each accepted sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win  <= '{default: '0};
            r_temp <= '0;
        end else if (bus.temp_valid) begin
            r_win  <= w_win_nxt;
            r_temp <= w_sum[TEMP_W+1:2];
        end
    end
`else
    // register the latest accepted sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_temp <= '0;
        else if (bus.temp_valid) r_temp <= bus.temp_raw;
    end
`endif

    assign bus.sensors    = w_sensors;
    assign bus.temp       = r_temp;
    assign bus.temp_ready = r_ready;
endmodule
